// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I front end: bubble encoding, opcodes used by
// Control, and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OP_ITYPE  = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry hold register that parks a fetched word while decode is stalled.
// Clear wins over drain, drain wins over load.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] wr_instr,
  input  logic [31:0] wr_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      full  <= 1'b0;
    end else if (clear || drain) begin
      full  <= 1'b0;
    end else if (load) begin
      instr <= wr_instr;
      pc    <= wr_pc;
      full  <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage with IF/ID register, imem req/ack handshake, stall/flush
// and branch redirect. Define FETCH_COUNT_EN to add the fetch_cnt_o counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic        valid_o
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);
  import riscv_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc_r, addr_r, pc_next4, tgt;
  logic         kill;
  logic         cap, buf_load, buf_drain, buf_clear, drain_ld;
  logic [31:0]  buf_instr, buf_pc;
  logic         buf_full;

  assign pc_next4 = pc_r + 32'd4;
  assign tgt      = align_pc(redirect_pc_i);

  // Word accepted straight into IF/ID vs. parked in the hold buffer.
  assign cap       = (state == REQ) && imem_ack_i && !redirect_i && !kill && !flush_i && !stall_i;
  assign buf_load  = (state == REQ) && imem_ack_i && !redirect_i && !kill && (flush_i || stall_i);
  assign buf_drain = (state == HOLD) && !redirect_i && !flush_i && !stall_i;
  assign buf_clear = (state == HOLD) && redirect_i;
  assign drain_ld  = buf_drain && buf_full;

  fetch_buffer u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .wr_instr (imem_data_i),
    .wr_pc    (pc_r),
    .instr    (buf_instr),
    .pc       (buf_pc),
    .full     (buf_full)
  );

  // addr_r tracks pc_r except while a killed request is still outstanding,
  // so the address stays stable until that request's ack.
  assign imem_addr_o = addr_r;
  assign opcode_o    = instr_o[6:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pc_r       <= RESET_PC;
      addr_r     <= RESET_PC;
      imem_req_o <= 1'b0;
      kill       <= 1'b0;
      instr_o    <= NOP_INSTR;
      pc_o       <= '0;
      valid_o    <= 1'b0;
    end else begin
      if (flush_i) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end else if (cap) begin
        instr_o <= imem_data_i;
        pc_o    <= pc_r;
        valid_o <= 1'b1;
      end else if (drain_ld) begin
        instr_o <= buf_instr;
        pc_o    <= buf_pc;
        valid_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (redirect_i) begin
            pc_r   <= tgt;
            addr_r <= tgt;
          end
          if (start_i) begin
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_i) begin
            pc_r <= tgt;
            if (imem_ack_i) begin
              addr_r <= tgt;
              kill   <= 1'b0;
            end else begin
              kill   <= 1'b1;
            end
          end else if (imem_ack_i) begin
            if (kill) begin
              kill   <= 1'b0;
              addr_r <= pc_r;
            end else begin
              pc_r   <= pc_next4;
              addr_r <= pc_next4;
              if (flush_i || stall_i) begin
                state      <= HOLD;
                imem_req_o <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc_r       <= tgt;
            addr_r     <= tgt;
            state      <= REQ;
            imem_req_o <= 1'b1;
          end else if (!flush_i && !stall_i) begin
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                cnt <= '0;
    else if (cap || drain_ld) cnt <= cnt + 32'd1;
  end
  assign fetch_cnt_o = cnt;
`endif

endmodule
